// File: rtl/alu_writeback.sv
// ALU writeback stage: takes one ALU result per accept, writes it to the register file,
// and for mul/div also writes the high product or remainder into R15.
// The status flags and the completed-operation counter are updated here as well.
module alu_writeback #(
    parameter int unsigned DATA_W   = 16,
    parameter logic [3:0]  R15_ADDR = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [3:0]        rd,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] alu_r15,
    input  logic              alu_neg,
    input  logic              alu_zero,
    input  logic              alu_error,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              flag_neg,
    output logic              flag_zero,
    output logic              flag_err,
    output logic [15:0]       op_count
);

    typedef enum logic [1:0] {StIdle, StWrLo, StWrHi, StErr} state_e;

    state_e              state_q, state_d;
    logic                rf_we_q, rf_we_d;
    logic [3:0]          rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic [DATA_W-1:0]   r15_q, r15_d;
    logic                dbl_q, dbl_d;
    logic                flag_neg_q, flag_neg_d;
    logic                flag_zero_q, flag_zero_d;
    logic                flag_err_q, flag_err_d;
    logic [15:0]         op_count_q, op_count_d;

    logic accept;
    logic op_legal;
    logic op_double;

    assign in_ready  = (state_q == StIdle);
    assign accept    = in_valid && in_ready;
    assign op_double = (opcode == 4'b0100) || (opcode == 4'b0101);
    assign op_legal  = (opcode == 4'b0000) || (opcode == 4'b0001) || op_double;

    // Next-state logic; the write port is computed one cycle ahead so rf_* are true registers.
    always_comb begin
        state_d     = state_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        r15_d       = r15_q;
        dbl_d       = dbl_q;
        flag_neg_d  = flag_neg_q;
        flag_zero_d = flag_zero_q;
        flag_err_d  = flag_err_q;
        op_count_d  = op_count_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    r15_d = alu_r15;
                    dbl_d = op_double;
                    if (op_legal && !alu_error) begin
                        state_d     = StWrLo;
                        rf_we_d     = 1'b1;
                        rf_waddr_d  = rd;
                        rf_wdata_d  = alu_out;
                        flag_neg_d  = alu_neg;
                        flag_zero_d = alu_zero;
                        flag_err_d  = 1'b0;
                    end else begin
                        // Error results never report ALU sign/zero status.
                        state_d     = StErr;
                        flag_neg_d  = 1'b0;
                        flag_zero_d = 1'b0;
                        flag_err_d  = 1'b1;
                    end
                end
            end
            StWrLo: begin
                if (dbl_q) begin
                    state_d    = StWrHi;
                    rf_we_d    = 1'b1;
                    rf_waddr_d = R15_ADDR;
                    rf_wdata_d = r15_q;
                end else begin
                    state_d    = StIdle;
                    op_count_d = op_count_q + 16'd1;
                end
            end
            StWrHi: begin
                state_d    = StIdle;
                op_count_d = op_count_q + 16'd1;
            end
            StErr: begin
                state_d    = StIdle;
                op_count_d = op_count_q + 16'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset also aborts any write still pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            r15_q       <= '0;
            dbl_q       <= 1'b0;
            flag_neg_q  <= 1'b0;
            flag_zero_q <= 1'b0;
            flag_err_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            r15_q       <= r15_d;
            dbl_q       <= dbl_d;
            flag_neg_q  <= flag_neg_d;
            flag_zero_q <= flag_zero_d;
            flag_err_q  <= flag_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign flag_neg  = flag_neg_q;
    assign flag_zero = flag_zero_q;
    assign flag_err  = flag_err_q;
    assign op_count  = op_count_q;

endmodule
